// File: rtl/cpu7_ifu_fetch_sched.sv
// cpu7 IFU fetch-request scheduler: picks the next fetch PC, drives the instruction-bus
// request handshake and tracks in-flight fetches so that cancelled responses are discarded.
module cpu7_ifu_fetch_sched #(
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned CNTW      = 3
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [31:0]     pc_init,
  input  logic            exu_ifu_except,
  input  logic [31:0]     exu_ifu_eentry,
  input  logic            exu_ifu_ertn_e,
  input  logic [31:0]     exu_ifu_era,
  input  logic            exu_ifu_br_taken,
  input  logic [31:0]     exu_ifu_br_target,
  input  logic            exu_ifu_stall_req,
  output logic            inst_req,
  output logic [31:0]     inst_addr,
  input  logic            inst_addr_ok,
  output logic            inst_cancel,
  input  logic            inst_valid_f,
  output logic            fetch_vld_f,
  output logic [31:0]     fetch_pc_f,
  output logic [CNTW-1:0] outst_cnt,
  output logic            proto_err
);

  localparam int unsigned     PtrW    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTST - 1);
  localparam logic [CNTW-1:0] CntMax  = CNTW'(MAX_OUTST);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_bf_q, pc_bf_d;
  logic [CNTW-1:0] outst_q, outst_d;
  logic [CNTW-1:0] drop_q, drop_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            perr_q, perr_d;
  logic [31:0]     fifo_q [MAX_OUTST];
  logic [31:0]     fifo_d [MAX_OUTST];

  logic        run;
  logic        redirect;
  logic [31:0] target;
  logic        accept;
  logic        resp;

  always_comb begin
    run      = (state_q == StRun);
    redirect = exu_ifu_except | exu_ifu_ertn_e | exu_ifu_br_taken;
    if (exu_ifu_except) begin
      target = exu_ifu_eentry;
    end else if (exu_ifu_ertn_e) begin
      target = exu_ifu_era;
    end else begin
      target = exu_ifu_br_target;
    end

    inst_req    = run & ~redirect & ~exu_ifu_stall_req & (outst_q < CntMax);
    accept      = inst_req & inst_addr_ok;
    resp        = inst_valid_f & (outst_q != '0);
    // A response popped during a redirect belongs to the cancelled stream.
    fetch_vld_f = resp & (drop_q == '0) & ~(run & redirect);
    inst_cancel = run & redirect & (outst_q != '0);
  end

  always_comb begin
    state_d  = state_q;
    pc_bf_d  = pc_bf_q;
    outst_d  = outst_q;
    drop_d   = drop_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    perr_d   = perr_q | (inst_valid_f & (outst_q == '0));
    fifo_d   = fifo_q;

    unique case (state_q)
      StBoot: begin
        pc_bf_d = pc_init;
        state_d = StRun;
      end
      StRun: begin
        if (redirect) begin
          pc_bf_d = target;
        end else if (accept) begin
          pc_bf_d = pc_bf_q + 32'd4;
        end
      end
      default: state_d = StBoot;
    endcase

    if (accept) begin
      fifo_d[wr_ptr_q] = pc_bf_q;
      wr_ptr_d         = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (resp) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
    end

    unique case ({accept, resp})
      2'b10:   outst_d = outst_q + CNTW'(1);
      2'b01:   outst_d = outst_q - CNTW'(1);
      default: outst_d = outst_q;
    endcase

    // Everything still in flight after this cycle's pop is stale once we redirect.
    if (run && redirect) begin
      drop_d = outst_q - CNTW'(resp);
    end else if (resp && (drop_q != '0)) begin
      drop_d = drop_q - CNTW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StBoot;
      pc_bf_q  <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      perr_q   <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTST); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_bf_q  <= pc_bf_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      perr_q   <= perr_d;
      fifo_q   <= fifo_d;
    end
  end

  assign inst_addr  = pc_bf_q;
  assign fetch_pc_f = fifo_q[rd_ptr_q];
  assign outst_cnt  = outst_q;
  assign proto_err  = perr_q;

endmodule

// File: tb/tb_cpu7_ifu_fetch_sched.sv
// Bench for cpu7_ifu_fetch_sched: per-cycle vector table for the request side, with a
// scoreboard of issued fetch PCs checked against each returned response.
module tb_cpu7_ifu_fetch_sched;

  localparam logic [31:0] A  = 32'h1c00_0000;
  localparam logic [31:0] B  = 32'h1c00_0100;
  localparam logic [31:0] E  = 32'h1c00_8000;
  localparam logic [31:0] R  = 32'h1c00_a000;
  localparam logic [31:0] B2 = 32'h1c00_0200;
  localparam logic [31:0] W  = 32'hffff_fffc;

  logic        clock;
  logic        resetn;
  logic [31:0] pc_init;
  logic        exu_ifu_except;
  logic [31:0] exu_ifu_eentry;
  logic        exu_ifu_ertn_e;
  logic [31:0] exu_ifu_era;
  logic        exu_ifu_br_taken;
  logic [31:0] exu_ifu_br_target;
  logic        exu_ifu_stall_req;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_cancel;
  logic        inst_valid_f;
  logic        fetch_vld_f;
  logic [31:0] fetch_pc_f;
  logic [2:0]  outst_cnt;
  logic        proto_err;

  cpu7_ifu_fetch_sched #(
    .MAX_OUTST(2),
    .CNTW     (3)
  ) dut (
    .clock            (clock),
    .resetn           (resetn),
    .pc_init          (pc_init),
    .exu_ifu_except   (exu_ifu_except),
    .exu_ifu_eentry   (exu_ifu_eentry),
    .exu_ifu_ertn_e   (exu_ifu_ertn_e),
    .exu_ifu_era      (exu_ifu_era),
    .exu_ifu_br_taken (exu_ifu_br_taken),
    .exu_ifu_br_target(exu_ifu_br_target),
    .exu_ifu_stall_req(exu_ifu_stall_req),
    .inst_req         (inst_req),
    .inst_addr        (inst_addr),
    .inst_addr_ok     (inst_addr_ok),
    .inst_cancel      (inst_cancel),
    .inst_valid_f     (inst_valid_f),
    .fetch_vld_f      (fetch_vld_f),
    .fetch_pc_f       (fetch_pc_f),
    .outst_cnt        (outst_cnt),
    .proto_err        (proto_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        stall, ok, valid, exc, ertn, br;
    logic [31:0] te, tr, tb;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_cancel;
    int          exp_cnt;
    logic        exp_perr;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    bit          live;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic st, input logic ok, input logic vl, input logic ex,
                              input logic er, input logic br, input logic [31:0] te,
                              input logic [31:0] tr, input logic [31:0] tbt, input logic rq,
                              input logic [31:0] ad, input logic cn, input int cnt,
                              input logic pe);
    vec_t v;
    v.stall = st; v.ok = ok; v.valid = vl; v.exc = ex; v.ertn = er; v.br = br;
    v.te = te; v.tr = tr; v.tb = tbt;
    v.exp_req = rq; v.exp_addr = ad; v.exp_cancel = cn; v.exp_cnt = cnt; v.exp_perr = pe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    exu_ifu_stall_req = v.stall;
    inst_addr_ok      = v.ok;
    inst_valid_f      = v.valid;
    exu_ifu_except    = v.exc;
    exu_ifu_ertn_e    = v.ertn;
    exu_ifu_br_taken  = v.br;
    exu_ifu_eentry    = v.te;
    exu_ifu_era       = v.tr;
    exu_ifu_br_target = v.tb;
  endtask

  initial begin
    vec_t idle;
    //        st ok vl ex er br  eentry era brt   req addr      cancel cnt perr
    // boot and in-order delivery
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, E, R, B, 0, 32'h0,     0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, E, R, B, 1, A,         0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, E, R, B, 1, A + 4,     0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, E, R, B, 1, A + 8,     0, 1, 0));
    // fill to MAX_OUTST, then a response frees a slot only for the next cycle
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, E, R, B, 1, A + 12,    0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, E, R, B, 0, A + 16,    0, 2, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, E, R, B, 0, A + 16,    0, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, E, R, B, 1, A + 16,    0, 1, 0));
    // branch flush with two outstanding
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, E, R, B, 0, A + 20,    1, 2, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, E, R, B, 0, B,         0, 2, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, E, R, B, 1, B,         0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, E, R, B, 1, B,         0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, E, R, B, 1, B + 4,     0, 1, 0));
    // priority: all three redirects, then ertn alone with a same-cycle response
    vecs.push_back(mk(0, 1, 0, 1, 1, 1, E, R, B2, 0, B + 4,    0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, E, R, B2, 1, E,        0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, B2, R, B2, 0, E + 4,   1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, E, R, B, 1, R,         0, 0, 0));
    // redirect during stall, then wrap past 0xfffffffc
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, E, R, W, 0, R,         0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, E, R, B, 0, W,         0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, E, R, B, 1, W,         0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, E, R, B, 0, 32'h0,     0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, E, R, B, 1, 32'h0,     0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, E, R, B, 1, 32'h4,     0, 1, 0));
    // stray response with nothing outstanding
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, E, R, B, 1, 32'h4,     0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, E, R, B, 1, 32'h4,     0, 0, 1));

    idle = mk(0, 0, 0, 0, 0, 0, E, R, B, 0, 32'h0, 0, 0, 0);
    pc_init = A;
    resetn  = 1'b0;
    drive(idle);
    repeat (3) @(negedge clock);
    chk("rst_req", {31'b0, inst_req}, 32'h0);
    chk("rst_addr", inst_addr, 32'h0);
    chk("rst_cancel", {31'b0, inst_cancel}, 32'h0);
    chk("rst_vld", {31'b0, fetch_vld_f}, 32'h0);
    chk("rst_cnt", 32'(outst_cnt), 32'h0);
    chk("rst_perr", {31'b0, proto_err}, 32'h0);

    resetn = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      bit   redir;
      v = vecs[i];
      redir = v.exc | v.ertn | v.br;
      drive(v);
      #4;
      chk($sformatf("req[%0d]", i), {31'b0, inst_req}, {31'b0, v.exp_req});
      chk($sformatf("addr[%0d]", i), inst_addr, v.exp_addr);
      chk($sformatf("cancel[%0d]", i), {31'b0, inst_cancel}, {31'b0, v.exp_cancel});
      chk($sformatf("cnt[%0d]", i), 32'(outst_cnt), v.exp_cnt);
      chk($sformatf("perr[%0d]", i), {31'b0, proto_err}, {31'b0, v.exp_perr});
      if (v.valid && sb.size() > 0) begin
        sb_t e;
        bit  exp_vld;
        e = sb.pop_front();
        exp_vld = e.live && !redir;
        chk($sformatf("vld[%0d]", i), {31'b0, fetch_vld_f}, {31'b0, exp_vld});
        if (exp_vld) chk($sformatf("fpc[%0d]", i), fetch_pc_f, e.pc);
      end else begin
        chk($sformatf("novld[%0d]", i), {31'b0, fetch_vld_f}, 32'h0);
      end
      if (redir) begin
        foreach (sb[k]) sb[k].live = 1'b0;
      end
      if (v.exp_req && v.ok) sb.push_back('{pc: v.exp_addr, live: 1'b1});
      @(negedge clock);
    end
    chk("sb_drained", 32'(sb.size()), 32'h0);

    // Reset mid-operation with a request in flight clears everything at once.
    drive(idle);
    inst_addr_ok = 1'b1;
    #4;
    chk("pre_rst_req", {31'b0, inst_req}, 32'h1);
    @(negedge clock);
    inst_addr_ok = 1'b0;
    #1;
    chk("pre_rst_cnt", 32'(outst_cnt), 32'h1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(outst_cnt), 32'h0);
    chk("mid_rst_perr", {31'b0, proto_err}, 32'h0);
    chk("mid_rst_req", {31'b0, inst_req}, 32'h0);
    chk("mid_rst_addr", inst_addr, 32'h0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
